// File: rtl/inst_loader_pkg.sv
// Shared types for the boot-time program loader.
//   Types      : core-wide instruction word and address types.
//   LoaderType : loader FSM state encoding and stream framing constants.
package Types;
    typedef logic [31:0] inst_t;
    typedef logic [31:0] addr_t;
endpackage

package LoaderType;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        CSUM  = 3'd4,
        DONE  = 3'd5,
        ERROR = 3'd6
    } loader_state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned HDR_BYTES      = 2;

    // Lane index of the byte that completes a word.
    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);
endpackage

// File: rtl/inst_loader_byte_packer.sv
// byte_packer: assembles four stream bytes into one little-endian word.
// Ports:
//   clk, rst    : clock, synchronous active-low reset
//   clear       : drop any partial word and restart at lane 0
//   byte_strobe : a byte is accepted this cycle
//   data        : the accepted byte
//   word        : assembly register with the incoming byte merged into its lane
//   word_valid  : the incoming byte completes a word (word is then complete)
module byte_packer
    import Types::*;
    import LoaderType::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       byte_strobe,
    input  logic [7:0] data,
    output inst_t      word,
    output logic       word_valid
);
    logic [1:0] lane_r;
    inst_t      asm_r;

    // Lane counter and assembly register; lane wraps 3 -> 0 on its own.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_r <= 2'd0;
            asm_r  <= 32'h0000_0000;
        end else if (clear) begin
            lane_r <= 2'd0;
            asm_r  <= 32'h0000_0000;
        end else if (byte_strobe) begin
            lane_r <= lane_r + 2'd1;
            asm_r  <= word;
        end else begin
            lane_r <= lane_r;
            asm_r  <= asm_r;
        end
    end

    // Merge the incoming byte into its lane so a complete word is visible
    // in the same cycle its last byte is accepted.
    always_comb begin
        word                        = asm_r;
        word[{lane_r, 3'b000} +: 8] = data;
        word_valid                  = byte_strobe && (lane_r == LAST_LANE);
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: boot-time program loader for the single-cycle MIPS core.
// Receives a byte stream (2-byte LE word count N, then 4N LE payload bytes)
// and writes each word into the instruction fetcher via load/load_inst/
// load_addr/chip_select, holding the CPU in reset until the image is in.
// Optional feature macro: INST_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte over the payload; mismatch ends the session in ERROR.
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   start                          : begin a session (IDLE/DONE/ERROR only)
//   byte_valid, byte_data          : stream input
//   byte_ready                     : loader accepts a byte this cycle
//   load, load_inst, load_addr     : one-cycle fetcher write
//   chip_select                    : fetcher select for the session
//   cpu_hold                       : keep the CPU in reset
//   busy, done, error              : session status levels
module inst_loader
    import Types::*;
    import LoaderType::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter addr_t       BASE_ADDR = 32'h0000_0000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       byte_valid,
    input  logic [7:0] byte_data,
    output logic       byte_ready,
    output logic       load,
    output inst_t      load_inst,
    output addr_t      load_addr,
    output logic       chip_select,
    output logic       cpu_hold,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int unsigned IDX_W = $clog2(DEPTH) + 1;

    loader_state_t    state_r;
    loader_state_t    next_state;
    logic [IDX_W-1:0] word_idx_r;
    logic [15:0]      count_r;

    logic        accept;
    logic        pack_strobe;
    logic        pack_clear;
    logic        word_valid;
    inst_t       word;
    logic [15:0] hdr_count;
    logic        hdr_bad;
    logic        last_word;
    logic        final_word;

    logic busy_nx;
    logic ready_nx;
    logic chip_nx;
    logic load_nx;

    assign accept      = byte_valid && byte_ready;
    assign pack_strobe = accept && (state_r == DATA);
    assign pack_clear  = (state_r != DATA);
    assign hdr_count   = {byte_data, count_r[7:0]};
    assign hdr_bad     = (hdr_count == 16'd0) || (32'(hdr_count) > DEPTH);
    assign last_word   = (16'(word_idx_r) == (count_r - 16'd1));
    assign final_word  = pack_strobe && word_valid && last_word;

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clear       (pack_clear),
        .byte_strobe (pack_strobe),
        .data        (byte_data),
        .word        (word),
        .word_valid  (word_valid)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state;
        end
    end

    // Header capture and word index; the index restarts whenever DATA is left.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r    <= 16'd0;
            word_idx_r <= '0;
        end else begin
            if (accept && (state_r == HDR0)) begin
                count_r <= {8'd0, byte_data};
            end else if (accept && (state_r == HDR1)) begin
                count_r <= hdr_count;
            end else begin
                count_r <= count_r;
            end

            if (state_r != DATA) begin
                word_idx_r <= '0;
            end else if (pack_strobe && word_valid) begin
                word_idx_r <= word_idx_r + 1'b1;
            end else begin
                word_idx_r <= word_idx_r;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] xor_r;

    // Running XOR over payload bytes, cleared at the start of each header.
    always_ff @(posedge clk) begin
        if (!rst) begin
            xor_r <= 8'd0;
        end else if (state_r == HDR0) begin
            xor_r <= 8'd0;
        end else if (pack_strobe) begin
            xor_r <= xor_r ^ byte_data;
        end else begin
            xor_r <= xor_r;
        end
    end
`else
    logic all_packed;
    assign all_packed = (16'(word_idx_r) == count_r);
`endif

    // Next-state logic.
    always_comb begin
        next_state = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state = HDR0;
                else       next_state = IDLE;
            end
            HDR0: begin
                if (accept) next_state = HDR1;
                else        next_state = HDR0;
            end
            HDR1: begin
                if (accept) next_state = hdr_bad ? ERROR : DATA;
                else        next_state = HDR1;
            end
            DATA: begin
`ifdef INST_LOADER_CHECKSUM_EN
                if (final_word) next_state = CSUM;
                else            next_state = DATA;
`else
                // The cycle after the last word is packed carries its strobe;
                // leave DATA on the edge that ends that cycle.
                if (all_packed) next_state = DONE;
                else            next_state = DATA;
`endif
            end
`ifdef INST_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) next_state = (byte_data == xor_r) ? DONE : ERROR;
                else        next_state = CSUM;
            end
`endif
            DONE: begin
                if (start) next_state = HDR0;
                else       next_state = DONE;
            end
            ERROR: begin
                if (start) next_state = HDR0;
                else       next_state = ERROR;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the next state, registered below.
    always_comb begin
        busy_nx = (next_state == HDR0) || (next_state == HDR1) ||
                  (next_state == DATA) || (next_state == CSUM);
`ifdef INST_LOADER_CHECKSUM_EN
        ready_nx = busy_nx;
`else
        // No byte may be taken while the final strobe is out.
        ready_nx = busy_nx && !final_word;
`endif
        chip_nx = (next_state == HDR0) || (next_state == HDR1) ||
                  (next_state == DATA) || (pack_strobe && word_valid);
        load_nx = pack_strobe && word_valid;
    end

    // Output registers; word and address are latched with the strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            byte_ready  <= 1'b0;
            load        <= 1'b0;
            load_inst   <= 32'h0000_0000;
            load_addr   <= BASE_ADDR;
            chip_select <= 1'b0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            byte_ready  <= ready_nx;
            load        <= load_nx;
            chip_select <= chip_nx;
            cpu_hold    <= (next_state != DONE);
            busy        <= busy_nx;
            done        <= (next_state == DONE);
            error       <= (next_state == ERROR);
            if (load_nx) begin
                load_inst <= word;
                load_addr <= BASE_ADDR + addr_t'({word_idx_r, 2'b00});
            end else begin
                load_inst <= load_inst;
                load_addr <= load_addr;
            end
        end
    end
endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench for inst_loader: stimulus tasks push expected fetcher
// writes into a queue; a negedge monitor pops and compares on every strobe.
module tb_inst_loader;
    import Types::*;

    localparam logic [31:0] EXP_BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        load;
    logic [31:0] load_inst;
    logic [31:0] load_addr;
    logic        chip_select;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    always #5 clk = ~clk;

    inst_loader #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .load        (load),
        .load_inst   (load_inst),
        .load_addr   (load_addr),
        .chip_select (chip_select),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          acc_cyc = 0;
    logic [7:0]  run_xor;
    logic [31:0] img [0:1];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: every strobe must match the oldest expected write and land
    // exactly one cycle after its 4th byte was accepted.
    always @(negedge clk) begin
        if (load === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_load", 32'(load), 32'd0);
            end else begin
                mon_e = q.pop_front();
                check("load_addr", load_addr, mon_e.addr);
                check("load_inst", load_inst, mon_e.inst);
                check("strobe_cycle", 32'(cyc), 32'(mon_e.cyc + 1));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok         = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        for (int t = 0; t < 40 && !ok; t++) begin
            @(negedge clk);
            if (byte_ready === 1'b1) begin
                acc_cyc = cyc;
                ok      = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        byte_valid = 1'b0;
        check("byte_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_header(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        run_xor = 8'h00;
    endtask

    // Sends one word LSB first; optionally pulses start before byte 2.
    task automatic send_word(input logic [31:0] w, input int idx, input int gap,
                             input bit pulse);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (pulse && i == 2) do_start();
            send_byte(w[8*i +: 8]);
            run_xor = run_xor ^ w[8*i +: 8];
            if (i == 3) begin
                e.addr = EXP_BASE + (32'(idx) << 2);
                e.inst = w;
                e.cyc  = acc_cyc;
                q.push_back(e);
            end
            idle(gap);
        end
    endtask

    task automatic send_image(input int n, input int gap);
        send_header(16'(n));
        for (int i = 0; i < n; i++) send_word(img[i], i, gap, 1'b0);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
    endtask

    task automatic wait_end(input string name, input bit exp_done);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 30 && !seen; t++) begin
            @(negedge clk);
            if (done === 1'b1 || error === 1'b1) seen = 1'b1;
        end
        check({name, "_ended"}, 32'(seen), 32'd1);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_error"}, 32'(error), 32'(!exp_done));
        check({name, "_cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        run_xor    = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        // Reset values
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_load", 32'(load), 32'd0);
        check("rst_load_inst", load_inst, 32'h0000_0000);
        check("rst_load_addr", load_addr, EXP_BASE);
        check("rst_chip_select", 32'(chip_select), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b1;
        idle(1);

        // Back-to-back two-word image
        img[0] = 32'h2008_0005;
        img[1] = 32'h0000_0000;
        do_start();
        check("s1_chip_select", 32'(chip_select), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        check("s1_byte_ready", 32'(byte_ready), 32'd1);
        send_image(2, 0);
        wait_end("s1", 1'b1);
        check("s1_end_chip_select", 32'(chip_select), 32'd0);
        check("s1_end_byte_ready", 32'(byte_ready), 32'd0);
        check("s1_end_busy", 32'(busy), 32'd0);

        // Start from DONE, same image with byte_valid toggling
        do_start();
        check("s2_cpu_hold", 32'(cpu_hold), 32'd1);
        check("s2_done", 32'(done), 32'd0);
        check("s2_busy", 32'(busy), 32'd1);
        send_image(2, 1);
        wait_end("s2", 1'b1);

        // start pulsed mid-word is ignored
        do_start();
        send_header(16'd1);
        send_word(32'h4433_2211, 0, 0, 1'b1);
`ifdef INST_LOADER_CHECKSUM_EN
        send_byte(run_xor);
`endif
        wait_end("s3", 1'b1);

        // Bad headers: N=0 and N=DEPTH+1
        do_start();
        send_header(16'd0);
        wait_end("n_zero", 1'b0);
        check("n_zero_byte_ready", 32'(byte_ready), 32'd0);
        do_start();
        send_header(16'd1025);
        wait_end("n_big", 1'b0);

        // Reset mid-word: partial word discarded, no strobe
        do_start();
        send_header(16'd1);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_byte_ready", 32'(byte_ready), 32'd0);
        check("mid_rst_chip_select", 32'(chip_select), 32'd0);
        check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("mid_rst_error", 32'(error), 32'd0);
        rst = 1'b1;
        idle(2);
        check("after_rst_idle_busy", 32'(busy), 32'd0);
        img[0] = 32'hDEAD_BEEF;
        do_start();
        send_image(1, 0);
        wait_end("after_rst", 1'b1);

`ifdef INST_LOADER_CHECKSUM_EN
        // Checksum 01^02^03^04 = 04
        do_start();
        send_header(16'd1);
        send_word(32'h0403_0201, 0, 0, 1'b0);
        send_byte(8'h04);
        wait_end("csum_ok", 1'b1);
        do_start();
        send_header(16'd1);
        send_word(32'h0403_0201, 0, 0, 1'b0);
        send_byte(8'h05);
        wait_end("csum_bad", 1'b0);
`endif

        idle(3);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
